// File: rtl/day9_coord_parser.sv
// Byte-serial ASCII parser for "x,y" lines: turns a character stream into
// coordinate pairs for the area stage, with sticky error/overflow/done status.
module day9_coord_parser #(
  parameter int W     = 17,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             byte_last,
  output logic [W-1:0]     x_coord,
  output logic [W-1:0]     y_coord,
  output logic             coord_valid,
  output logic [CNT_W-1:0] pair_count,
  output logic             parse_error,
  output logic             overflow,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a byte is consumed on every rising edge where byte_valid is
  // high (no backpressure); coord_valid is a one-cycle pulse with no ready.
  typedef enum logic [1:0] {
    S_X    = 2'd0,
    S_Y    = 2'd1,
    S_SKIP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_x_q, acc_x_d;
  logic [W-1:0]     acc_y_q, acc_y_d;
  logic             have_digit_q, have_digit_d;
  logic             ovf_line_q, ovf_line_d;
  logic [W-1:0]     x_coord_q, x_coord_d;
  logic [W-1:0]     y_coord_q, y_coord_d;
  logic             coord_valid_q, coord_valid_d;
  logic [CNT_W-1:0] pair_count_q, pair_count_d;
  logic             parse_error_q, parse_error_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [W+3:0]     acc_sel;
  logic [W+3:0]     prod;
  logic             is_digit;
  logic             is_comma;
  logic             is_nl;
  logic             is_cr;
  logic             digit_ovf;
  logic             emit;
  logic [W-1:0]     emit_x;
  logic [W-1:0]     emit_y;

  always_comb begin
    state_d       = state_q;
    acc_x_d       = acc_x_q;
    acc_y_d       = acc_y_q;
    have_digit_d  = have_digit_q;
    ovf_line_d    = ovf_line_q;
    x_coord_d     = x_coord_q;
    y_coord_d     = y_coord_q;
    coord_valid_d = 1'b0;
    pair_count_d  = pair_count_q;
    parse_error_d = parse_error_q;
    overflow_d    = overflow_q;
    done_d        = done_q;
    emit          = 1'b0;
    emit_x        = acc_x_q;
    emit_y        = acc_y_q;

    is_digit = (byte_in >= 8'h30) && (byte_in <= 8'h39);
    is_comma = (byte_in == 8'h2C);
    is_nl    = (byte_in == 8'h0A);
    is_cr    = (byte_in == 8'h0D);

    // acc*10 + digit with 4 guard bits so any overflow is visible
    acc_sel   = {4'b0, (state_q == S_Y) ? acc_y_q : acc_x_q};
    prod      = (acc_sel << 3) + (acc_sel << 1) + {{W{1'b0}}, byte_in[3:0]};
    digit_ovf = |prod[W+3:W];

    if (byte_valid && (state_q != S_DONE)) begin
      if (!is_cr) begin
        case (state_q)
          S_X: begin
            if (is_digit) begin
              acc_x_d      = prod[W-1:0];
              have_digit_d = 1'b1;
              if (digit_ovf) ovf_line_d = 1'b1;
            end else if (is_comma) begin
              if (have_digit_q) begin
                state_d      = S_Y;
                have_digit_d = 1'b0;
              end else begin
                parse_error_d = 1'b1;
                state_d       = S_SKIP;
              end
            end else if (is_nl) begin
              if (have_digit_q) parse_error_d = 1'b1;
              acc_x_d      = '0;
              acc_y_d      = '0;
              have_digit_d = 1'b0;
              ovf_line_d   = 1'b0;
            end else begin
              parse_error_d = 1'b1;
              state_d       = S_SKIP;
            end
          end
          S_Y: begin
            if (is_digit) begin
              acc_y_d      = prod[W-1:0];
              have_digit_d = 1'b1;
              if (digit_ovf) ovf_line_d = 1'b1;
            end else if (is_nl) begin
              // An empty y field is malformed even if x already overflowed
              if (!have_digit_q)    parse_error_d = 1'b1;
              else if (ovf_line_q)  overflow_d    = 1'b1;
              else                  emit          = 1'b1;
              state_d      = S_X;
              acc_x_d      = '0;
              acc_y_d      = '0;
              have_digit_d = 1'b0;
              ovf_line_d   = 1'b0;
            end else begin
              parse_error_d = 1'b1;
              state_d       = S_SKIP;
            end
          end
          S_SKIP: begin
            if (is_nl) begin
              state_d      = S_X;
              acc_x_d      = '0;
              acc_y_d      = '0;
              have_digit_d = 1'b0;
              ovf_line_d   = 1'b0;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end

      // Close out an unterminated final line using the post-byte state
      if (byte_last) begin
        if ((state_d == S_Y) && have_digit_d) begin
          if (ovf_line_d) begin
            overflow_d = 1'b1;
          end else begin
            emit   = 1'b1;
            emit_x = acc_x_d;
            emit_y = acc_y_d;
          end
        end else if ((state_d == S_X) && have_digit_d) begin
          parse_error_d = 1'b1;
        end
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    if (emit) begin
      x_coord_d     = emit_x;
      y_coord_d     = emit_y;
      coord_valid_d = 1'b1;
      if (pair_count_q != {CNT_W{1'b1}}) pair_count_d = pair_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_X;
      acc_x_q       <= '0;
      acc_y_q       <= '0;
      have_digit_q  <= 1'b0;
      ovf_line_q    <= 1'b0;
      x_coord_q     <= '0;
      y_coord_q     <= '0;
      coord_valid_q <= 1'b0;
      pair_count_q  <= '0;
      parse_error_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_x_q       <= acc_x_d;
      acc_y_q       <= acc_y_d;
      have_digit_q  <= have_digit_d;
      ovf_line_q    <= ovf_line_d;
      x_coord_q     <= x_coord_d;
      y_coord_q     <= y_coord_d;
      coord_valid_q <= coord_valid_d;
      pair_count_q  <= pair_count_d;
      parse_error_q <= parse_error_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  assign x_coord     = x_coord_q;
  assign y_coord     = y_coord_q;
  assign coord_valid = coord_valid_q;
  assign pair_count  = pair_count_q;
  assign parse_error = parse_error_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule
